// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate generator: decodes the immediate of a 32-bit instruction
// into an XLEN-wide value and buffers {err, imm} in a 2-entry skid buffer.
module imm_extend_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_out,
    output logic            imm_err
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_extend_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] imm;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t      state_q, state_d;
    entry_t      head_q, skid_q, new_entry;
    logic [31:0] imm32;
    logic        sign_ext;
    logic        push, pop;
    logic        load_head_new, load_head_skid, load_skid;

    // The opcode field never contributes to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Every format is first built as a 32-bit value, then sign- or zero-extended to XLEN.
    // NOTE: every variable assigned in this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        imm32         = '0;
        sign_ext      = 1'b1;
        new_entry     = '0;
        case (imm_src)
            3'b000: imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: imm32 = {instr[31:12], 12'b0};
            3'b100: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b101: begin
                sign_ext = 1'b0;
                imm32    = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            end
            3'b110: begin
                sign_ext = 1'b0;
                imm32    = {27'b0, instr[19:15]};
            end
            default: begin
                sign_ext      = 1'b0;
                new_entry.err = 1'b1;
            end
        endcase
        new_entry.imm = sign_ext ? XLEN'(signed'(imm32)) : XLEN'(imm32);
    end

    assign in_ready  = (state_q != FULL) & ~rst;
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d       = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the two data slots are reset along with the state so that no entry from
    // before a reset can ever reappear on imm_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_new) begin
                head_q <= new_entry;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    // The head slot keeps its last value after a pop, so mask it while empty.
    assign imm_out = (state_q == EMPTY) ? '0 : head_q.imm;
    assign imm_err = (state_q == EMPTY) ? 1'b0 : head_q.err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share stimulus,
// each with a scoreboard queue filled on accepted input and drained on accepted output.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic        out_ready;

    logic        in_ready32, out_valid32, imm_err32;
    logic [31:0] imm_out32;
    logic        in_ready64, out_valid64, imm_err64;
    logic [63:0] imm_out64;

    int checks = 0;
    int errors = 0;

    logic [64:0] q32[$];
    logic [64:0] q64[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid32),
        .out_ready(out_ready), .imm_out(imm_out32), .imm_err(imm_err32)
    );

    imm_extend_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid64),
        .out_ready(out_ready), .imm_out(imm_out64), .imm_err(imm_err64)
    );

    task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference decode written directly in 64 bits; upper half cleared for XLEN=32.
    function automatic logic [64:0] model(input logic [31:0] i, input logic [2:0] src, input int xlen);
        logic [63:0] v;
        logic        e;
        e = 1'b0;
        case (src)
            3'd0: v = {{52{i[31]}}, i[31:20]};
            3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: v = {{32{i[31]}}, i[31:12], 12'b0};
            3'd4: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd5: v = (xlen == 32) ? {59'b0, i[24:20]} : {58'b0, i[25:20]};
            3'd6: v = {59'b0, i[19:15]};
            default: begin
                v = '0;
                e = 1'b1;
            end
        endcase
        if (xlen == 32) v[63:32] = '0;
        return {e, v};
    endfunction

    // Scoreboard: push on accepted input, pop and compare on accepted output.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready32) q32.push_back(model(instr, imm_src, 32));
            if (in_valid && in_ready64) q64.push_back(model(instr, imm_src, 64));
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) check("underflow32", 65'(q32.size()), 65'd1);
                else check("sb32", {imm_err32, 32'b0, imm_out32}, q32.pop_front());
            end
            if (out_valid64 && out_ready) begin
                if (q64.size() == 0) check("underflow64", 65'(q64.size()), 65'd1);
                else check("sb64", {imm_err64, imm_out64}, q64.pop_front());
            end
        end
    end

    task automatic push_txn(input logic [31:0] ins, input logic [2:0] src);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        instr    = ins;
        imm_src  = src;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready32) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("push_timeout", 65'd0, 65'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_hold(input logic [31:0] ins, input logic [2:0] src);
        out_ready = 1'b0;
        push_txn(ins, src);
        @(negedge clk);
    endtask

    task automatic drain_one();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a_ins, b_ins, c_ins;
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid32, 1'b0);
        check("rst_in_ready", in_ready32, 1'b0);
        check("rst_imm_out", imm_out64, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready64, 1'b1);

        // Spec vectors
        send_hold(32'hFFF00093, 3'b000);
        check("i_valid", out_valid32, 1'b1);
        check("i_imm32", imm_out32, 32'hFFFFFFFF);
        check("i_err", imm_err32, 1'b0);
        drain_one();
        send_hold(32'hFE000EE3, 3'b010);
        check("b_imm32", imm_out32, 32'hFFFFFFFC);
        drain_one();
        send_hold(32'h00112623, 3'b001);
        check("s_imm32", imm_out32, 32'h0000000C);
        drain_one();
        send_hold(32'h800000B7, 3'b011);
        check("u_imm64", imm_out64, 64'hFFFFFFFF80000000);
        check("u_imm32", imm_out32, 32'h80000000);
        drain_one();
        send_hold(32'h03F01013, 3'b101);
        check("shamt_imm64", imm_out64, 64'h3F);
        check("shamt_imm32", imm_out32, 32'h1F);
        drain_one();
        send_hold(32'h000FD073, 3'b110);
        check("zimm_imm64", imm_out64, 64'h1F);
        drain_one();

        // Backpressure: A, B fill the buffer; C is held off until out_ready rises.
        a_ins = 32'h12345093; b_ins = 32'h8765A0B7; c_ins = 32'hF0F0F0EF;
        out_ready = 1'b0;
        push_txn(a_ins, 3'b000);
        push_txn(b_ins, 3'b011);
        in_valid = 1'b1; instr = c_ins; imm_src = 3'b100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready32, 1'b0);
            check("bp_head_stable", {imm_err32, 32'b0, imm_out32}, model(a_ins, 3'b000, 32));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_deliver_a", out_valid32, 1'b1);
        @(negedge clk);
        check("bp_deliver_b", out_valid32, 1'b1);
        check("bp_c_accept", in_ready32, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_deliver_c", out_valid64, 1'b1);
        @(negedge clk);
        check("bp_empty", out_valid64, 1'b0);

        // Full-rate stream of 8 entries; the last one uses the reserved format.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            instr    = $urandom;
            imm_src  = k[2:0];
            @(negedge clk);
            check("stream_in_ready", in_ready32, 1'b1);
            if (k > 0) check("stream_out_valid", out_valid32, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_valid", out_valid32, 1'b1);
        check("reserved_err", imm_err64, 1'b1);
        check("reserved_imm", imm_out64, 64'd0);
        @(negedge clk);
        check("stream_done", out_valid32, 1'b0);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            instr     = $urandom;
            imm_src   = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rand_q32_empty", 65'(q32.size()), 65'd0);
        check("rand_q64_empty", 65'(q64.size()), 65'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        push_txn(32'h7FF00013, 3'b000);
        push_txn(32'hABCDE037, 3'b011);
        @(negedge clk);
        check("full_in_ready", in_ready32, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid32, 1'b0);
        check("arst_imm_out", imm_out64, 64'd0);
        check("arst_in_ready", in_ready64, 1'b0);
        q32.delete();
        q64.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready32, 1'b1);
        check("post_rst_no_stale", out_valid64, 1'b0);
        send_hold(32'h00500093, 3'b000);
        check("post_rst_imm32", imm_out32, 32'd5);
        check("post_rst_imm64", imm_out64, 64'd5);
        drain_one();
        @(negedge clk);
        check("final_empty", out_valid32, 1'b0);
        check("final_q_empty", 65'(q32.size() + q64.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
